// File: rtl/mux_cfg_chain_shadow.sv
// Routing mux whose select memory is loaded through a serial ccff chain into a
// shadow register and swapped into the active memory only on an accepted commit.
module mux_cfg_chain_shadow #(
    parameter int NUM_INPUTS = 8,
    parameter int MODE       = 0,
    parameter int REG_OUT    = 0,
    localparam int MEM_SIZE  = (MODE == 0) ? NUM_INPUTS : $clog2(NUM_INPUTS)
) (
    input  logic                  prog_clk,
    input  logic                  pReset_n,
    input  logic [NUM_INPUTS-1:0] in,
    input  logic                  ccff_head,
    input  logic                  cfg_en,
    input  logic                  cfg_commit,
    output logic                  ccff_tail,
    output logic                  out,
    output logic [MEM_SIZE-1:0]   mem_q,
    output logic                  cfg_ready,
    output logic                  cfg_err,
    output logic                  sel_err
);

    localparam int CW = $clog2(MEM_SIZE + 1);
    localparam logic [CW-1:0] MEM_CNT = CW'(MEM_SIZE);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_READY = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [CW-1:0]       count_q, count_d;
    logic [MEM_SIZE-1:0] shadow_q, shadow_d;
    logic [MEM_SIZE-1:0] active_q, active_d;
    logic                cfg_err_q, cfg_err_d;
    logic                commit_ok;
    logic                commit_rej;
    logic                route_c;
    logic                sel_err_c;

    // A commit is honoured only with a full shadow word and no concurrent shift.
    assign commit_ok  = cfg_commit && !cfg_en && (state_q == ST_READY);
    assign commit_rej = cfg_commit && !commit_ok;

    assign shadow_d[0] = cfg_en ? ccff_head : shadow_q[0];
    for (genvar gi = 1; gi < MEM_SIZE; gi++) begin : g_chain
        assign shadow_d[gi] = cfg_en ? shadow_q[gi-1] : shadow_q[gi];
    end

    assign active_d  = commit_ok ? shadow_q : active_q;
    assign cfg_err_d = commit_ok ? 1'b0 : (commit_rej ? 1'b1 : cfg_err_q);

    always_ff @(posedge prog_clk) begin
        if (!pReset_n) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            shadow_q  <= '0;
            active_q  <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        if (commit_ok) begin
            count_d = '0;
        end else if (cfg_en && (count_q != MEM_CNT)) begin
            count_d = count_q + 1'b1;
        end
        case (state_q)
            ST_IDLE: begin
                if (cfg_en) begin
                    state_d = (MEM_SIZE == 1) ? ST_READY : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (cfg_en && (count_q == MEM_CNT - 1'b1)) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                if (commit_ok) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cfg_ready = (state_q == ST_READY);
        ccff_tail = shadow_q[MEM_SIZE-1];
        mem_q     = active_q;
        cfg_err   = cfg_err_q;
        sel_err   = sel_err_c;
    end

    // Decode looks only at active memory, so shifting can never disturb routing.
    if (MODE == 0) begin : g_onehot
        logic seen_hot;
        logic multi_hot;

        always_comb begin
            seen_hot  = 1'b0;
            multi_hot = 1'b0;
            for (int i = 0; i < MEM_SIZE; i++) begin
                if (active_q[i]) begin
                    if (seen_hot) begin
                        multi_hot = 1'b1;
                    end
                    seen_hot = 1'b1;
                end
            end
        end

        assign sel_err_c = multi_hot;
        assign route_c   = (|(in & active_q)) & ~multi_hot;
    end else begin : g_binary
        logic in_range;

        assign in_range  = (32'(active_q) < NUM_INPUTS);
        assign sel_err_c = ~in_range;
        assign route_c   = in_range ? in[active_q] : 1'b0;
    end

    if (REG_OUT != 0) begin : g_out_reg
        logic out_q;

        always_ff @(posedge prog_clk) begin
            if (!pReset_n) begin
                out_q <= 1'b0;
            end else begin
                out_q <= route_c;
            end
        end

        assign out = out_q;
    end else begin : g_out_comb
        assign out = route_c;
    end

endmodule

// File: tb/tb_mux_cfg_chain_shadow.sv
// Drives three mux variants (one-hot, binary N=5, one-hot registered) with shared
// stimulus and compares every output against a bit-list reference model each cycle.
module tb_mux_cfg_chain_shadow;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       head;
    logic       en;
    logic       commit;
    logic [7:0] in_bus;

    logic       a_tail, a_out, a_rdy, a_cerr, a_serr;
    logic [7:0] a_mem;
    logic       b_tail, b_out, b_rdy, b_cerr, b_serr;
    logic [2:0] b_mem;
    logic       c_tail, c_out, c_rdy, c_cerr, c_serr;
    logic [7:0] c_mem;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mux_cfg_chain_shadow #(.NUM_INPUTS(8), .MODE(0), .REG_OUT(0)) u_a (
        .prog_clk(clk), .pReset_n(rst_n), .in(in_bus), .ccff_head(head),
        .cfg_en(en), .cfg_commit(commit), .ccff_tail(a_tail), .out(a_out),
        .mem_q(a_mem), .cfg_ready(a_rdy), .cfg_err(a_cerr), .sel_err(a_serr)
    );

    mux_cfg_chain_shadow #(.NUM_INPUTS(5), .MODE(1), .REG_OUT(0)) u_b (
        .prog_clk(clk), .pReset_n(rst_n), .in(in_bus[4:0]), .ccff_head(head),
        .cfg_en(en), .cfg_commit(commit), .ccff_tail(b_tail), .out(b_out),
        .mem_q(b_mem), .cfg_ready(b_rdy), .cfg_err(b_cerr), .sel_err(b_serr)
    );

    mux_cfg_chain_shadow #(.NUM_INPUTS(8), .MODE(0), .REG_OUT(1)) u_c (
        .prog_clk(clk), .pReset_n(rst_n), .in(in_bus), .ccff_head(head),
        .cfg_en(en), .cfg_commit(commit), .ccff_tail(c_tail), .out(c_out),
        .mem_q(c_mem), .cfg_ready(c_rdy), .cfg_err(c_cerr), .sel_err(c_serr)
    );

    // Reference model: per-variant shadow word, shifted-bit count, committed word.
    int         m_msz [3] = '{8, 3, 8};
    int         m_n   [3] = '{8, 5, 8};
    int         m_mode[3] = '{0, 1, 0};
    int         m_reg [3] = '{0, 0, 1};
    string      m_name[3] = '{"oh8", "bin5", "oh8r"};
    logic [7:0] m_shadow[3];
    logic [7:0] m_active[3];
    int         m_cnt[3];
    bit         m_err[3];
    bit         m_outq[3];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    // Returns {sel_err, routed bit} for a committed word.
    function automatic logic [1:0] ref_decode(input int k, input logic [7:0] act, input logic [7:0] din);
        int hits = 0;
        int idx  = 0;
        int v;
        if (m_mode[k] == 0) begin
            for (int i = 0; i < m_n[k]; i++) begin
                if (act[i]) begin
                    hits++;
                    idx = i;
                end
            end
            if (hits == 0) return 2'b00;
            if (hits == 1) return {1'b0, din[idx]};
            return 2'b10;
        end
        v = int'(act);
        if (v < m_n[k]) return {1'b0, din[v]};
        return 2'b10;
    endfunction

    task automatic model_edge();
        for (int k = 0; k < 3; k++) begin
            logic [7:0] mask;
            logic [1:0] dec;
            bit         ok;
            mask = 8'((1 << m_msz[k]) - 1);
            if (!rst_n) begin
                m_shadow[k] = '0;
                m_active[k] = '0;
                m_cnt[k]    = 0;
                m_err[k]    = 1'b0;
                m_outq[k]   = 1'b0;
            end else begin
                dec = ref_decode(k, m_active[k], in_bus);
                if (m_reg[k] != 0) m_outq[k] = dec[0];
                ok = commit && !en && (m_cnt[k] == m_msz[k]);
                if (ok) begin
                    m_active[k] = m_shadow[k];
                    m_cnt[k]    = 0;
                    m_err[k]    = 1'b0;
                end else if (commit) begin
                    m_err[k] = 1'b1;
                end
                if (en) begin
                    m_shadow[k] = ((m_shadow[k] << 1) | {7'd0, head}) & mask;
                    if (m_cnt[k] < m_msz[k]) m_cnt[k]++;
                end
            end
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 3; k++) begin
            logic [1:0] dec;
            logic       g_tail, g_out, g_rdy, g_cerr, g_serr, e_out;
            logic [7:0] g_mem;
            dec = ref_decode(k, m_active[k], in_bus);
            case (k)
                0: begin g_tail = a_tail; g_out = a_out; g_rdy = a_rdy; g_cerr = a_cerr; g_serr = a_serr; g_mem = a_mem; end
                1: begin g_tail = b_tail; g_out = b_out; g_rdy = b_rdy; g_cerr = b_cerr; g_serr = b_serr; g_mem = {5'd0, b_mem}; end
                default: begin g_tail = c_tail; g_out = c_out; g_rdy = c_rdy; g_cerr = c_cerr; g_serr = c_serr; g_mem = c_mem; end
            endcase
            e_out = (m_reg[k] != 0) ? m_outq[k] : dec[0];
            check_eq({m_name[k], ".out"},       32'(g_out),  32'(e_out));
            check_eq({m_name[k], ".mem_q"},     32'(g_mem),  32'(m_active[k]));
            check_eq({m_name[k], ".sel_err"},   32'(g_serr), 32'(dec[1]));
            check_eq({m_name[k], ".cfg_err"},   32'(g_cerr), 32'(m_err[k]));
            check_eq({m_name[k], ".cfg_ready"}, 32'(g_rdy),  32'(m_cnt[k] == m_msz[k]));
            check_eq({m_name[k], ".ccff_tail"}, 32'(g_tail), 32'(m_shadow[k][m_msz[k]-1]));
        end
    endtask

    task automatic step(input bit r, input bit e, input bit c, input bit h, input logic [7:0] din);
        rst_n  = r;
        en     = e;
        commit = c;
        head   = h;
        in_bus = din;
        #1;
        check_all();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    // First bit shifted is bit (nbits-1), so a full 8-bit load leaves shadow == v.
    task automatic shift_pattern(input logic [7:0] v, input int nbits);
        logic [7:0] pat;
        pat = v;
        for (int i = nbits - 1; i >= 0; i--) begin
            step(1'b1, 1'b1, 1'b0, pat[i], 8'($urandom));
        end
    endtask

    task automatic idle_toggle(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, 8'($urandom));
        end
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; commit = 1'b0; head = 1'b0; in_bus = '0;

        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'hFF);

        // One-hot select of input 2, then reload while still routing in[2].
        shift_pattern(8'h04, 8);
        step(1'b1, 1'b0, 1'b1, 1'b0, 8'h04);
        idle_toggle(6);
        shift_pattern(8'h40, 8);
        step(1'b1, 1'b0, 1'b1, 1'b0, 8'hBB);
        idle_toggle(3);

        // Binary variant: 3 routes, 6 is illegal, 1 clears the error.
        shift_pattern(8'h03, 8);
        step(1'b1, 1'b0, 1'b1, 1'b0, 8'h08);
        idle_toggle(4);
        shift_pattern(8'h06, 8);
        step(1'b1, 1'b0, 1'b1, 1'b0, 8'hFF);
        idle_toggle(2);
        shift_pattern(8'h01, 8);
        step(1'b1, 1'b0, 1'b1, 1'b0, 8'h02);
        idle_toggle(3);

        // Early commit is rejected on the 8-bit variants, then a full load clears it.
        shift_pattern(8'h05, 3);
        step(1'b1, 1'b0, 1'b1, 1'b0, 8'h55);
        shift_pattern(8'h20, 8);
        step(1'b1, 1'b0, 1'b1, 1'b0, 8'h20);
        idle_toggle(2);

        // Shift and commit together: shift happens, commit rejected.
        shift_pattern(8'h80, 8);
        step(1'b1, 1'b1, 1'b1, 1'b1, 8'hA5);
        idle_toggle(2);

        // Reset mid-shift, then a fresh load and commit.
        shift_pattern(8'h0F, 4);
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'hFF);
        shift_pattern(8'h10, 8);
        step(1'b1, 1'b0, 1'b1, 1'b0, 8'h10);
        idle_toggle(4);

        for (int i = 0; i < 800; i++) begin
            step(($urandom_range(0, 79) != 0),
                 ($urandom_range(0, 9) < 6),
                 ($urandom_range(0, 9) < 2),
                 1'($urandom),
                 8'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
